// File: rtl/pipeline_exec_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipeline_exec_ctrl_if
// Bundles the execution controller's UART byte interface, pipeline control and
// instruction-memory write port.
//   master : controller side (drives o_* signals, receives i_* signals)
//   slave  : environment side (UART, pipeline top, instruction memory)
// Signals:
//   i_rx_data/i_rx_valid  received UART byte and its one-cycle valid pulse
//   i_tx_done             UART finished sending the last byte (one-cycle pulse)
//   i_halt                pipeline reports that HALT reached WB
//   o_tx_data/o_tx_start  byte to transmit and its one-cycle start pulse
//   o_pipe_en/o_pipe_rst  pipeline clock enable and one-cycle pipeline reset
//   o_imem_we/addr/data   instruction memory write port
//   o_busy                controller is not waiting for a command
// -----------------------------------------------------------------------------
interface pipeline_exec_ctrl_if #(
    parameter int NB_BYTE      = 8,
    parameter int NB_INSTR     = 32,
    parameter int NB_IMEM_ADDR = 10
);
    logic [NB_BYTE-1:0]      i_rx_data;
    logic                    i_rx_valid;
    logic                    i_tx_done;
    logic                    i_halt;
    logic [NB_BYTE-1:0]      o_tx_data;
    logic                    o_tx_start;
    logic                    o_pipe_en;
    logic                    o_pipe_rst;
    logic                    o_imem_we;
    logic [NB_IMEM_ADDR-1:0] o_imem_addr;
    logic [NB_INSTR-1:0]     o_imem_data;
    logic                    o_busy;

    modport master (
        input  i_rx_data, i_rx_valid, i_tx_done, i_halt,
        output o_tx_data, o_tx_start, o_pipe_en, o_pipe_rst,
               o_imem_we, o_imem_addr, o_imem_data, o_busy
    );

    modport slave (
        output i_rx_data, i_rx_valid, i_tx_done, i_halt,
        input  o_tx_data, o_tx_start, o_pipe_en, o_pipe_rst,
               o_imem_we, o_imem_addr, o_imem_data, o_busy
    );
endinterface

// File: rtl/pipeline_exec_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_exec_ctrl
// Execution controller for the 5-stage MIPS pipeline. Loads a program received
// over UART into instruction memory ('L'), runs it continuously ('R') or one
// cycle at a time ('S', then 'N' per step, 'E' to leave), and after each run or
// step reports the accumulated enabled-cycle count over UART, MSB byte first.
// Ports:
//   i_clk  system clock, rising edge
//   i_rst  synchronous, active-low reset
//   bus    pipeline_exec_ctrl_if.master (UART bytes, pipeline control, imem write)
// -----------------------------------------------------------------------------
module pipeline_exec_ctrl #(
    parameter int                  NB_BYTE      = 8,
    parameter int                  NB_INSTR     = 32,
    parameter int                  NB_IMEM_ADDR = 10,
    parameter int                  NB_CYCLES    = 32,
    parameter logic [NB_INSTR-1:0] HALT_INSTR   = 32'hFFFF_FFFF
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    pipeline_exec_ctrl_if.master bus
);
    localparam int NB_TX      = NB_CYCLES / NB_BYTE;   // report bytes
    localparam int BPW        = NB_INSTR / NB_BYTE;    // bytes per instruction
    localparam int TX_IDX_W   = (NB_TX > 1) ? $clog2(NB_TX) : 1;
    localparam int BYTE_IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

    localparam logic [NB_BYTE-1:0] CMD_LOAD = NB_BYTE'(8'h4C);
    localparam logic [NB_BYTE-1:0] CMD_RUN  = NB_BYTE'(8'h52);
    localparam logic [NB_BYTE-1:0] CMD_STEP = NB_BYTE'(8'h53);
    localparam logic [NB_BYTE-1:0] CMD_NEXT = NB_BYTE'(8'h4E);
    localparam logic [NB_BYTE-1:0] CMD_END  = NB_BYTE'(8'h45);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_RUN, S_STEP_WAIT, S_STEP_EXEC, S_REPORT_SEND, S_REPORT_WAIT
    } state_t;

    state_t                  state_q, state_d;
    state_t                  ret_q, ret_d;         // where to go after the report
    logic [BYTE_IDX_W-1:0]   byte_idx_q, byte_idx_d;
    logic [NB_INSTR-1:0]     word_q, word_d;
    logic [NB_IMEM_ADDR-1:0] addr_q, addr_d;
    logic [NB_CYCLES-1:0]    cnt_q, cnt_d;
    logic [NB_CYCLES-1:0]    snap_q, snap_d;
    logic [TX_IDX_W-1:0]     tx_idx_q, tx_idx_d;
    logic                    we_q, we_d;
    logic                    pipe_rst_q, pipe_rst_d;

    logic                    pipe_en;
    logic                    reporting;
    logic [NB_CYCLES-1:0]    tx_src;
    logic [NB_CYCLES-1:0]    tx_shift;

    assign pipe_en   = (state_q == S_RUN) || (state_q == S_STEP_EXEC);
    assign reporting = (state_q == S_REPORT_SEND) || (state_q == S_REPORT_WAIT);

    // The first byte goes out in the same cycle the snapshot is taken, so it
    // reads the live counter; later bytes read the snapshot.
    assign tx_src   = ((state_q == S_REPORT_SEND) && (tx_idx_q == '0)) ? cnt_q : snap_q;
    assign tx_shift = tx_src >> (NB_BYTE * (NB_TX - 1 - int'(tx_idx_q)));

    assign bus.o_tx_data   = reporting ? tx_shift[NB_BYTE-1:0] : '0;
    assign bus.o_tx_start  = (state_q == S_REPORT_SEND);
    assign bus.o_pipe_en   = pipe_en;
    assign bus.o_pipe_rst  = pipe_rst_q;
    assign bus.o_imem_we   = we_q;
    assign bus.o_imem_addr = addr_q;
    assign bus.o_imem_data = word_q;
    assign bus.o_busy      = (state_q != S_IDLE) && (state_q != S_STEP_WAIT);

    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        state_d    = state_q;
        ret_d      = ret_q;
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        snap_d     = snap_q;
        tx_idx_d   = tx_idx_q;
        we_d       = 1'b0;
        pipe_rst_d = 1'b0;

        // Saturating cycle counter.
        if (pipe_en && (cnt_q != '1)) begin
            cnt_d = cnt_q + NB_CYCLES'(1);
        end
        // Address advances after its write; it never wraps past the top word.
        if (we_q && (addr_q != '1)) begin
            addr_d = addr_q + NB_IMEM_ADDR'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (bus.i_rx_valid) begin
                    if (bus.i_rx_data == CMD_LOAD) begin
                        state_d    = S_LOAD;
                        pipe_rst_d = 1'b1;
                        cnt_d      = '0;
                        addr_d     = '0;
                        byte_idx_d = '0;
                    end else if (bus.i_rx_data == CMD_RUN) begin
                        state_d = S_RUN;
                    end else if (bus.i_rx_data == CMD_STEP) begin
                        state_d = S_STEP_WAIT;
                    end
                end
            end
            S_LOAD: begin
                if (bus.i_rx_valid) begin
                    word_d     = {word_q[NB_INSTR-NB_BYTE-1:0], bus.i_rx_data};
                    byte_idx_d = byte_idx_q + BYTE_IDX_W'(1);
                    if (byte_idx_q == BYTE_IDX_W'(BPW - 1)) begin
                        we_d = 1'b1;
                        // The final write lands in the following cycle, already in IDLE.
                        if ((word_d == HALT_INSTR) || (addr_q == '1)) begin
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            S_RUN: begin
                if (bus.i_halt) begin
                    state_d = S_REPORT_SEND;
                    ret_d   = S_IDLE;
                end
            end
            S_STEP_WAIT: begin
                if (bus.i_rx_valid) begin
                    if (bus.i_rx_data == CMD_NEXT) begin
                        state_d = S_STEP_EXEC;
                    end else if (bus.i_rx_data == CMD_END) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_STEP_EXEC: begin
                state_d = S_REPORT_SEND;
                ret_d   = bus.i_halt ? S_IDLE : S_STEP_WAIT;
            end
            S_REPORT_SEND: begin
                if (tx_idx_q == '0) begin
                    snap_d = cnt_q;
                end
                state_d = S_REPORT_WAIT;
            end
            S_REPORT_WAIT: begin
                if (bus.i_tx_done) begin
                    if (tx_idx_q == TX_IDX_W'(NB_TX - 1)) begin
                        tx_idx_d = '0;
                        state_d  = ret_q;
                    end else begin
                        tx_idx_d = tx_idx_q + TX_IDX_W'(1);
                        state_d  = S_REPORT_SEND;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q    <= S_IDLE;
            ret_q      <= S_IDLE;
            byte_idx_q <= '0;
            word_q     <= '0;
            addr_q     <= '0;
            cnt_q      <= '0;
            snap_q     <= '0;
            tx_idx_q   <= '0;
            we_q       <= 1'b0;
            pipe_rst_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ret_q      <= ret_d;
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            snap_q     <= snap_d;
            tx_idx_q   <= tx_idx_d;
            we_q       <= we_d;
            pipe_rst_q <= pipe_rst_d;
        end
    end
endmodule

// File: tb/tb_pipeline_exec_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_exec_ctrl
// Directed bench for pipeline_exec_ctrl. Inputs change 2 time units after a
// rising edge; outputs are sampled on the falling edge. A UART responder
// answers every o_tx_start with an i_tx_done pulse a few cycles later, and a
// monitor logs enables, pipeline resets, imem writes and transmitted bytes.
// -----------------------------------------------------------------------------
module tb_pipeline_exec_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipeline_exec_ctrl_if bus ();

    pipeline_exec_ctrl dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.master)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Monitor state (written only by the monitor process).
    int          en_cnt      = 0;
    int          rst_cnt     = 0;
    int          overlap_err = 0;
    int          hold_err    = 0;
    logic        tx_busy     = 1'b0;
    logic [7:0]  last_tx     = 8'h00;
    logic [7:0]  tx_q [$];
    logic [9:0]  wr_addr [$];
    logic [31:0] wr_data [$];

    always @(negedge clk) begin
        if (bus.o_pipe_en)  en_cnt++;
        if (bus.o_pipe_rst) rst_cnt++;
        if (bus.o_imem_we) begin
            wr_addr.push_back(bus.o_imem_addr);
            wr_data.push_back(bus.o_imem_data);
        end
        if (tx_busy && !bus.o_tx_start && (bus.o_tx_data !== last_tx)) hold_err++;
        if (bus.o_tx_start) begin
            if (tx_busy) overlap_err++;
            tx_busy = 1'b1;
            last_tx = bus.o_tx_data;
            tx_q.push_back(bus.o_tx_data);
        end
        if (bus.i_tx_done) tx_busy = 1'b0;
    end

    // UART transmitter model: done pulse three cycles after each start.
    initial begin
        bus.i_tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.o_tx_start) begin
                repeat (3) @(posedge clk);
                #2 bus.i_tx_done = 1'b1;
                @(posedge clk);
                #2 bus.i_tx_done = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #2;
        bus.i_rx_data  = b;
        bus.i_rx_valid = 1'b1;
        @(posedge clk); #2;
        bus.i_rx_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic apply_reset();
        @(posedge clk); #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
    endtask

    // Halt is raised for exactly the cycle that follows the call.
    task automatic pulse_halt_now();
        bus.i_halt = 1'b1;
        @(posedge clk); #2;
        bus.i_halt = 1'b0;
    endtask

    task automatic wait_not_busy(input string tag, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!bus.o_busy) break;
        end
        n_checks++;
        if (i >= budget) $display("FAIL %s_timeout: o_busy still 1 after %0d cycles, required 0", tag, budget);
        else n_pass++;
    endtask

    task automatic check_tx(input string tag, input int base, input logic [7:0] exp [$]);
        logic [7:0] got;
        n_checks++;
        if (tx_q.size() - base !== exp.size())
            $display("FAIL %s_tx_count: got %0d bytes, required %0d", tag, tx_q.size() - base, exp.size());
        else n_pass++;
        for (int k = 0; k < exp.size(); k++) begin
            got = (tx_q.size() > base + k) ? tx_q[base + k] : 8'hxx;
            n_checks++;
            if (got !== exp[k]) $display("FAIL %s_tx_byte%0d: got %h, required %h", tag, k, got, exp[k]);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({bus.o_tx_data, bus.o_tx_start, bus.o_pipe_en, bus.o_pipe_rst, bus.o_imem_we,
             bus.o_imem_addr, bus.o_imem_data, bus.o_busy} !== '0)
            $display("FAIL reset_outputs: some output nonzero after reset (busy=%b en=%b)", bus.o_busy, bus.o_pipe_en);
        else n_pass++;

        send_byte(8'h52);
        idle_cycles(2);
        @(negedge clk);
        n_checks++;
        if (bus.o_pipe_en !== 1'b1) $display("FAIL run_before_reset_en: got %b, required 1", bus.o_pipe_en);
        else n_pass++;

        @(posedge clk); #2 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.o_pipe_en !== 1'b0) $display("FAIL reset_first_edge_en: got %b, required 0", bus.o_pipe_en);
        else n_pass++;
        n_checks++;
        if ({bus.o_tx_data, bus.o_tx_start, bus.o_pipe_rst, bus.o_imem_we,
             bus.o_imem_addr, bus.o_imem_data, bus.o_busy} !== '0)
            $display("FAIL reset_mid_run_outputs: some output nonzero (busy=%b)", bus.o_busy);
        else n_pass++;
        @(posedge clk); #2 rst = 1'b1;
        idle_cycles(2);
        @(negedge clk);
        n_checks++;
        if ({bus.o_pipe_en, bus.o_busy} !== 2'b00) $display("FAIL reset_release_idle: en,busy=%b, required 00", {bus.o_pipe_en, bus.o_busy});
        else n_pass++;
    endtask

    task automatic test_load();
        int w0 = wr_addr.size();
        int r0 = rst_cnt;
        logic [7:0] bytes [8] = '{8'h20, 8'h08, 8'h00, 8'h05, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        logic [9:0]  a;
        logic [31:0] d;
        send_byte(8'h4C);
        for (int k = 0; k < 8; k++) send_byte(bytes[k]);
        idle_cycles(3);
        @(negedge clk);
        n_checks++;
        if (rst_cnt - r0 !== 1) $display("FAIL load_pipe_rst: got %0d pulses, required 1", rst_cnt - r0);
        else n_pass++;
        n_checks++;
        if (wr_addr.size() - w0 !== 2) $display("FAIL load_writes: got %0d writes, required 2", wr_addr.size() - w0);
        else n_pass++;
        a = (wr_addr.size() > w0) ? wr_addr[w0] : 'x;
        d = (wr_data.size() > w0) ? wr_data[w0] : 'x;
        n_checks++;
        if ({a, d} !== {10'h000, 32'h2008_0005}) $display("FAIL load_word0: got addr %h data %h, required 000 20080005", a, d);
        else n_pass++;
        a = (wr_addr.size() > w0 + 1) ? wr_addr[w0 + 1] : 'x;
        d = (wr_data.size() > w0 + 1) ? wr_data[w0 + 1] : 'x;
        n_checks++;
        if ({a, d} !== {10'h001, 32'hFFFF_FFFF}) $display("FAIL load_word1: got addr %h data %h, required 001 ffffffff", a, d);
        else n_pass++;
        n_checks++;
        if (bus.o_busy !== 1'b0) $display("FAIL load_back_idle: busy got %b, required 0", bus.o_busy);
        else n_pass++;
    endtask

    task automatic test_run();
        int e0 = en_cnt;
        int t0 = tx_q.size();
        int n  = 0;
        int i;
        send_byte(8'h52);
        for (i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.o_pipe_en) n++;
            if (n == 6) break;
        end
        n_checks++;
        if (n != 6) $display("FAIL run_enable_timeout: saw %0d enabled cycles, required 6 before halt", n);
        else n_pass++;
        @(posedge clk); #2;
        pulse_halt_now();
        wait_not_busy("run", 200);
        n_checks++;
        if (en_cnt - e0 !== 7) $display("FAIL run_enable_cycles: got %0d, required 7", en_cnt - e0);
        else n_pass++;
        check_tx("run", t0, '{8'h00, 8'h00, 8'h00, 8'h07});
        n_checks++;
        if ({overlap_err, hold_err} !== 64'd0) $display("FAIL run_tx_handshake: overlap %0d hold %0d, required 0 0", overlap_err, hold_err);
        else n_pass++;
    endtask

    task automatic test_step();
        int e0;
        int t0;
        apply_reset();
        e0 = en_cnt;
        t0 = tx_q.size();
        send_byte(8'h53);
        idle_cycles(2);
        @(negedge clk);
        n_checks++;
        if ({bus.o_pipe_en, bus.o_busy} !== 2'b00) $display("FAIL step_wait_outputs: en,busy=%b, required 00", {bus.o_pipe_en, bus.o_busy});
        else n_pass++;
        send_byte(8'h4E);
        wait_not_busy("step1", 200);
        send_byte(8'h4E);
        wait_not_busy("step2", 200);
        send_byte(8'h45);
        idle_cycles(2);
        send_byte(8'h4E);   // in IDLE this must be ignored
        idle_cycles(4);
        @(negedge clk);
        n_checks++;
        if (en_cnt - e0 !== 2) $display("FAIL step_enable_cycles: got %0d, required 2", en_cnt - e0);
        else n_pass++;
        check_tx("step", t0, '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02});
        n_checks++;
        if (bus.o_busy !== 1'b0) $display("FAIL step_end_idle: busy got %b, required 0", bus.o_busy);
        else n_pass++;
    endtask

    task automatic test_ignore_and_halt_step();
        int e0 = en_cnt;
        int t0 = tx_q.size();
        int i;
        send_byte(8'h58);
        idle_cycles(4);
        @(negedge clk);
        n_checks++;
        if ({bus.o_busy, bus.o_pipe_en, bus.o_pipe_rst} !== 3'b000 || en_cnt != e0 || tx_q.size() != t0)
            $display("FAIL ignore_unknown: busy %b en %b enabled %0d tx %0d, required all 0", bus.o_busy, bus.o_pipe_en, en_cnt - e0, tx_q.size() - t0);
        else n_pass++;

        send_byte(8'h53);
        send_byte(8'h4E);
        pulse_halt_now();
        for (i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.o_tx_start) break;
        end
        send_byte(8'h52);   // lands in REPORT_WAIT, must be dropped
        wait_not_busy("halt_step", 200);
        send_byte(8'h4E);   // back in IDLE, must be ignored
        idle_cycles(4);
        @(negedge clk);
        n_checks++;
        if (en_cnt - e0 !== 1) $display("FAIL halt_step_enable_cycles: got %0d, required 1", en_cnt - e0);
        else n_pass++;
        check_tx("halt_step", t0, '{8'h00, 8'h00, 8'h00, 8'h03});
        n_checks++;
        if (bus.o_busy !== 1'b0) $display("FAIL halt_step_idle: busy got %b, required 0", bus.o_busy);
        else n_pass++;
    endtask

    task automatic test_addr_limit();
        int w0 = wr_addr.size();
        int r0 = rst_cnt;
        int e0;
        int t0;
        int errs = 0;
        logic [31:0] w;
        logic [9:0]  a_last;
        send_byte(8'h4C);
        for (int i = 0; i < 1024; i++) begin
            w = 32'h1234_0000 | 32'(i);
            send_byte(w[31:24]);
            send_byte(w[23:16]);
            send_byte(w[15:8]);
            send_byte(w[7:0]);
        end
        idle_cycles(4);
        @(negedge clk);
        n_checks++;
        if (rst_cnt - r0 !== 1) $display("FAIL limit_pipe_rst: got %0d pulses, required 1", rst_cnt - r0);
        else n_pass++;
        n_checks++;
        if (wr_addr.size() - w0 !== 1024) $display("FAIL limit_writes: got %0d writes, required 1024", wr_addr.size() - w0);
        else n_pass++;
        for (int i = 0; i < 1024 && (w0 + i) < wr_addr.size(); i++) begin
            if (wr_addr[w0 + i] !== 10'(i) || wr_data[w0 + i] !== (32'h1234_0000 | 32'(i))) errs++;
        end
        n_checks++;
        if (errs != 0) $display("FAIL limit_write_contents: %0d writes wrong, required 0", errs);
        else n_pass++;
        a_last = (wr_addr.size() > w0) ? wr_addr[wr_addr.size() - 1] : 'x;
        n_checks++;
        if (a_last !== 10'h3FF) $display("FAIL limit_last_addr: got %h, required 3ff", a_last);
        else n_pass++;
        n_checks++;
        if (bus.o_busy !== 1'b0) $display("FAIL limit_back_idle: busy got %b, required 0", bus.o_busy);
        else n_pass++;

        e0 = en_cnt;
        t0 = tx_q.size();
        send_byte(8'h52);
        pulse_halt_now();
        wait_not_busy("limit_run", 200);
        n_checks++;
        if (en_cnt - e0 !== 1) $display("FAIL limit_cmd_after_load: enabled cycles %0d, required 1", en_cnt - e0);
        else n_pass++;
        check_tx("limit_run", t0, '{8'h00, 8'h00, 8'h00, 8'h01});
    endtask

    initial begin
        rst            = 1'b0;
        bus.i_rx_data  = 8'h00;
        bus.i_rx_valid = 1'b0;
        bus.i_halt     = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;

        test_reset();
        test_load();
        test_run();
        test_step();
        test_ignore_and_halt_step();
        test_addr_limit();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/pipeline_exec_ctrl.md
Name: pipeline_exec_ctrl

Overview:
Execution controller for the 5-stage MIPS pipeline, sitting between the UART (rx/tx byte interfaces) and the pipeline top. It loads the program into instruction memory, then sequences execution in continuous (RUN) or single-cycle (STEP) mode by gating the pipeline enable. After each run or step it counts the enabled cycles and reports the count over UART.

Parameters:
NB_BYTE, 8, UART byte width
NB_INSTR, 32, instruction word width
NB_IMEM_ADDR, 10, instruction memory address width (word addressed)
NB_CYCLES, 32, cycle counter width (multiple of NB_BYTE)
HALT_INSTR, 32'hFFFF_FFFF, instruction encoding that terminates a load

Ports:
i_clk  in  1  system clock, all logic on rising edge
i_rst  in  1  reset, synchronous, active-low
i_rx_data  in  NB_BYTE  received UART byte
i_rx_valid  in  1  one-cycle pulse, i_rx_data valid
i_tx_done  in  1  one-cycle pulse, UART finished sending the last byte
i_halt  in  1  pipeline signals that HALT reached WB
o_tx_data  out  NB_BYTE  byte to transmit, held stable until i_tx_done
o_tx_start  out  1  one-cycle pulse, start transmission
o_pipe_en  out  1  pipeline clock enable (all stage registers and PC)
o_pipe_rst  out  1  one-cycle pulse, pipeline/PC reset
o_imem_we  out  1  instruction memory write strobe
o_imem_addr  out  NB_IMEM_ADDR  instruction memory write address
o_imem_data  out  NB_INSTR  instruction memory write data
o_busy  out  1  1 in any state other than IDLE/STEP_WAIT

Behaviour:
- Reset (i_rst=0 at clock edge): state=IDLE; all outputs 0; byte index, imem address, cycle counter, tx index=0. Reset mid-operation aborts any load/run/report immediately; no partial tx pulse.
- Commands are accepted only in IDLE (and STEP_WAIT as below); bytes in any other state are dropped. Unknown command bytes are ignored and the state does not change.
- IDLE: 'L'(8'h4C) -> LOAD, o_pipe_rst pulses 1 cycle, cycle counter and imem address cleared. 'R'(8'h52) -> RUN. 'S'(8'h53) -> STEP_WAIT.
- LOAD: bytes are assembled MSB first into a word, 4 bytes per word. On the 4th byte's next cycle: o_imem_we=1 for exactly 1 cycle with o_imem_data=word and o_imem_addr=current address; the address then increments. If word==HALT_INSTR, or the address just written was 2^NB_IMEM_ADDR-1, the write still occurs and the state returns to IDLE (no wrap-around).
- RUN: o_pipe_en=1 (combinational decode of state). Each cycle with o_pipe_en=1 increments the cycle counter, which saturates at all-ones. In the cycle i_halt=1, the enable is still 1 and counted; next state=REPORT_SEND, and the return target is IDLE.
- STEP_WAIT: 'N'(8'h4E) -> STEP_EXEC; 'E'(8'h45) -> IDLE; others are ignored.
- STEP_EXEC: lasts exactly 1 cycle with o_pipe_en=1 (counted), then goes to REPORT_SEND. The return target is IDLE if i_halt=1 in that cycle, else STEP_WAIT.
- REPORT_SEND: o_tx_data=cycle-counter byte[tx index], MSB byte first, o_tx_start pulses 1 cycle, then go to REPORT_WAIT. The counter value is snapshotted on entry to the first byte.
- REPORT_WAIT: o_tx_start=0 and o_tx_data is held. On i_tx_done, the tx index increments; after NB_CYCLES/NB_BYTE bytes, go to the return target with tx index cleared, otherwise go to REPORT_SEND. A done pulse arriving in the same cycle as start is ignored.
- o_pipe_en=0 in all states except RUN/STEP_EXEC. The cycle counter is cleared only by reset or 'L'; it accumulates across runs and steps.

Test Plan:
- Reset: i_rst=0 for 2 cycles while in RUN -> all outputs 0, state IDLE; o_pipe_en drops on the first reset edge.
- Load: 'L', bytes 20 08 00 05, then FF FF FF FF -> o_pipe_rst 1 pulse; writes addr0=32'h20080005 and addr1=32'hFFFFFFFF, one o_imem_we pulse each; returns to IDLE.
- Run: 'R', i_halt asserted on the 7th enabled cycle -> o_pipe_en high exactly 7 cycles; tx bytes 00 00 00 07 each sent after the previous i_tx_done; ends in IDLE.
- Step: 'S','N','N' (each tx completed), then 'E' -> 2 single-cycle enables; reports 00 00 00 01 then 00 00 00 02; ends in IDLE.
- Ignore and halt-in-step: byte 'X' in IDLE and 'R' during REPORT_WAIT -> no effect; 'N' with i_halt=1 in STEP_EXEC -> report sent, then IDLE.
- Address limit: load 1024 non-halt words -> 1024 writes, last at 10'h3FF; returns to IDLE and the following bytes are treated as commands.
